// File: rtl/professor_scheduler.sv
// Game-minute timer that periodically requests a professor visit (quiz).
// Define PROF_RANDOM_GAP_EN to add an LFSR-driven random extra gap.
module professor_scheduler #(
    parameter int TICKS_PER_MIN = 100000000,
    parameter int MIN_GAP       = 4,
    parameter int MAX_TIME      = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Halt,
    input  logic       Quiz,
    output logic [7:0] minutes,
    output logic       professor,
    output logic [3:0] quiz_cnt,
    output logic       time_up
);

    localparam int TW = (TICKS_PER_MIN > 2) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MIN - 1);
    localparam logic [7:0] GAP_INIT = 8'(MIN_GAP);
    localparam logic [8:0] MAX_T = 9'(MAX_TIME);

    localparam logic [2:0] STOP   = 3'd0;
    localparam logic [2:0] COUNT  = 3'd1;
    localparam logic [2:0] VISIT  = 3'd2;
    localparam logic [2:0] INQUIZ = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;

    logic [2:0]    state;
    logic [TW-1:0] tick;
    logic [7:0]    gap;
    logic [7:0]    reload;
    logic          wrap;
    logic          active;

`ifdef PROF_RANDOM_GAP_EN
    logic [7:0] lfsr;

    // Fibonacci taps 8,6,5,4; free-runs whenever out of reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign reload = GAP_INIT + {4'd0, lfsr[3:0]};
`else
    assign reload = GAP_INIT + 8'd8;
`endif

    assign wrap    = (tick == TICK_LAST);
    assign active  = (state == COUNT) || (state == VISIT) || (state == INQUIZ);
    assign time_up = ({1'b0, minutes} >= MAX_T);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= STOP;
            minutes   <= 8'd0;
            quiz_cnt  <= 4'd0;
            professor <= 1'b0;
            tick      <= '0;
            gap       <= GAP_INIT;
        end else if (Start) begin
            state     <= COUNT;
            minutes   <= 8'd0;
            quiz_cnt  <= 4'd0;
            professor <= 1'b0;
            tick      <= '0;
            gap       <= reload;
        end else if (active && Halt) begin
            // Halt freezes everything, including a wrap due this cycle
            state     <= HALTED;
            professor <= 1'b0;
        end else if (active) begin
            tick <= wrap ? '0 : tick + 1'b1;
            if (wrap && minutes != 8'hFF) begin
                minutes <= minutes + 8'd1;
            end
            case (state)
                COUNT: begin
                    if (wrap) begin
                        gap <= gap - 8'd1;
                        if (gap == 8'd1) begin
                            state     <= VISIT;
                            professor <= 1'b1;
                        end
                    end
                end
                VISIT: begin
                    if (Quiz) begin
                        state     <= INQUIZ;
                        professor <= 1'b0;
                        if (quiz_cnt != 4'hF) begin
                            quiz_cnt <= quiz_cnt + 4'd1;
                        end
                    end
                end
                INQUIZ: begin
                    professor <= 1'b0;
                    if (!Quiz) begin
                        state <= COUNT;
                        gap   <= reload;
                    end
                end
                default: begin
                    state <= STOP;
                end
            endcase
        end
    end

endmodule
